// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if
// Bundles every signal that crosses between the bus masters / bus slaves and
// the round-robin bus arbiter. Clock and reset are not part of the bundle.
//
// Signals (N = number of masters):
//   i_M_REQ     [N-1:0]     per-master transfer request, held until granted
//   i_M_WE      [N-1:0]     per-master write enable (0 = read)
//   i_M_HB      [2N-1:0]    per-master size code, master k at [2k+1:2k]
//   i_M_CE      [8N-1:0]    per-master one-hot slave select, master k at [8k+7:8k]
//   i_M_ADDR    [32N-1:0]   per-master address, master k at [32k+31:32k]
//   i_M_WDATA   [32N-1:0]   per-master write data, master k at [32k+31:32k]
//   o_M_GNT     [N-1:0]     one-cycle completion pulse to the owner
//   o_M_ERR     [N-1:0]     one-cycle timeout pulse, coincident with o_M_GNT
//   o_M_RDATA   [31:0]      read data broadcast, valid while o_M_GNT is high
//   o_BUS_ADDR  [31:0]      bus address
//   o_BUS_WDATA [31:0]      bus write data
//   o_BUS_WE                bus write enable
//   o_BUS_RE                bus read enable
//   o_BUS_HB    [1:0]       bus size code
//   o_BUS_CE    [7:0]       bus slave select
//   i_BUS_RDATA [31:0]      slave read data
//   i_BUS_RDY               slave completes the transfer this cycle
//   o_OWNER     [OW-1:0]    index of the current or last owner (debug)
//
// Modports:
//   slave  - the arbiter's view: consumes the i_* signals, drives the o_* signals
//   master - the surrounding system's view: drives i_*, observes o_*
interface bus_arbiter_if #(
  parameter int N = 2
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]      i_M_REQ;
  logic [N-1:0]      i_M_WE;
  logic [2*N-1:0]    i_M_HB;
  logic [8*N-1:0]    i_M_CE;
  logic [32*N-1:0]   i_M_ADDR;
  logic [32*N-1:0]   i_M_WDATA;
  logic [N-1:0]      o_M_GNT;
  logic [N-1:0]      o_M_ERR;
  logic [31:0]       o_M_RDATA;
  logic [31:0]       o_BUS_ADDR;
  logic [31:0]       o_BUS_WDATA;
  logic              o_BUS_WE;
  logic              o_BUS_RE;
  logic [1:0]        o_BUS_HB;
  logic [7:0]        o_BUS_CE;
  logic [31:0]       i_BUS_RDATA;
  logic              i_BUS_RDY;
  logic [OW-1:0]     o_OWNER;

  modport slave (
    input  i_M_REQ, i_M_WE, i_M_HB, i_M_CE, i_M_ADDR, i_M_WDATA,
    input  i_BUS_RDATA, i_BUS_RDY,
    output o_M_GNT, o_M_ERR, o_M_RDATA,
    output o_BUS_ADDR, o_BUS_WDATA, o_BUS_WE, o_BUS_RE, o_BUS_HB, o_BUS_CE,
    output o_OWNER
  );

  modport master (
    output i_M_REQ, i_M_WE, i_M_HB, i_M_CE, i_M_ADDR, i_M_WDATA,
    output i_BUS_RDATA, i_BUS_RDY,
    input  o_M_GNT, o_M_ERR, o_M_RDATA,
    input  o_BUS_ADDR, o_BUS_WDATA, o_BUS_WE, o_BUS_RE, o_BUS_HB, o_BUS_CE,
    input  o_OWNER
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Round-robin arbiter and multiplexer sharing one peripheral bus between N
// masters (master 0 is the core). Each transfer runs IDLE -> ACCESS -> RECOVER.
// ACCESS ends on i_BUS_RDY, or with an error after TIMEOUT cycles without it,
// or early if the owner withdraws its request.
//
// Parameters:
//   N        number of masters (2..4)
//   TIMEOUT  ACCESS cycles allowed before a transfer is terminated with error (>= 2)
//
// Ports:
//   i_CLK    rising-edge clock
//   i_RSTn   asynchronous active-low reset
//   bus      bus_arbiter_if.slave bundle (master requests, bus outputs, slave
//            responses, grant/error/read-data returns, owner debug index);
//            the interface's N must match this module's N
module bus_arbiter #(
  parameter int N       = 2,
  parameter int TIMEOUT = 16
) (
  input  logic          i_CLK,
  input  logic          i_RSTn,
  bus_arbiter_if.slave  bus
);

  localparam int          OW           = (N > 1) ? $clog2(N) : 1;
  localparam int          WW           = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t        state;
  logic [OW-1:0] ptr;
  logic [OW-1:0] owner;
  logic [WW-1:0] wcnt;

  logic [OW-1:0] cand;
  logic [OW-1:0] pick;
  logic          pick_valid;
  logic [OW-1:0] ptr_next;

  logic          owner_req;
  logic          owner_we;
  logic [1:0]    owner_hb;
  logic [7:0]    owner_ce;
  logic [31:0]   owner_addr;
  logic [31:0]   owner_wdata;

  logic          in_access;
  logic          done;
  logic          tmo;

  // Pick the first requester at or after ptr. Scanning the offsets from the
  // far end downwards lets the closest requester overwrite any later one.
  always_comb begin
    cand       = '0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = OW'((int'(ptr) + i) % N);
      if (bus.i_M_REQ[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  // Steer the latched owner's request fields. Constant-index slices keep the
  // mux free of variable part-selects.
  always_comb begin
    owner_req   = 1'b0;
    owner_we    = 1'b0;
    owner_hb    = '0;
    owner_ce    = '0;
    owner_addr  = '0;
    owner_wdata = '0;
    for (int k = 0; k < N; k++) begin
      if (owner == OW'(k)) begin
        owner_req   = bus.i_M_REQ[k];
        owner_we    = bus.i_M_WE[k];
        owner_hb    = bus.i_M_HB[2*k +: 2];
        owner_ce    = bus.i_M_CE[8*k +: 8];
        owner_addr  = bus.i_M_ADDR[32*k +: 32];
        owner_wdata = bus.i_M_WDATA[32*k +: 32];
      end
    end
  end

  // A withdrawn request takes precedence over both completion and timeout.
  // A ready that lands on the last allowed cycle counts as a normal completion.
  assign in_access = (state == ACCESS);
  assign done      = in_access && owner_req && bus.i_BUS_RDY;
  assign tmo       = in_access && owner_req && !bus.i_BUS_RDY && (wcnt == WW'(TIMEOUT - 1));
  assign ptr_next  = (owner == OW'(N - 1)) ? '0 : owner + 1'b1;

  // Transfer sequencer. RECOVER spends one idle cycle so that the finished
  // master's request, still high while it sees the grant, is not re-sampled.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      wcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick;
            wcnt  <= '0;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!owner_req) begin
            wcnt  <= '0;
            state <= IDLE;
          end else if (done || tmo) begin
            ptr   <= ptr_next;
            wcnt  <= '0;
            state <= RECOVER;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        RECOVER: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Bus and return paths are decoded from state, so an asynchronous reset
  // drops the bus immediately without waiting for a clock edge.
  always_comb begin
    bus.o_M_GNT     = '0;
    bus.o_M_ERR     = '0;
    bus.o_M_RDATA   = '0;
    bus.o_BUS_ADDR  = '0;
    bus.o_BUS_WDATA = '0;
    bus.o_BUS_WE    = 1'b0;
    bus.o_BUS_RE    = 1'b0;
    bus.o_BUS_HB    = '0;
    bus.o_BUS_CE    = '0;
    if (in_access) begin
      bus.o_BUS_ADDR  = owner_addr;
      bus.o_BUS_WDATA = owner_wdata;
      bus.o_BUS_WE    = owner_we;
      bus.o_BUS_RE    = ~owner_we;
      bus.o_BUS_HB    = owner_hb;
      bus.o_BUS_CE    = owner_ce;
    end
    for (int k = 0; k < N; k++) begin
      if (owner == OW'(k)) begin
        bus.o_M_GNT[k] = done || tmo;
        bus.o_M_ERR[k] = tmo;
      end
    end
    if (done) begin
      bus.o_M_RDATA = bus.i_BUS_RDATA;
    end else if (tmo) begin
      bus.o_M_RDATA = TIMEOUT_DATA;
    end
  end

  assign bus.o_OWNER = owner;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
// Directed bench for bus_arbiter with N=2, TIMEOUT=16. Inputs change 1 time
// unit after each rising edge; outputs are sampled on the falling edge.
module tb_bus_arbiter;

  localparam int N       = 2;
  localparam int TIMEOUT = 16;

  logic i_CLK;
  logic i_RSTn;

  int checks;
  int errors;

  bus_arbiter_if #(.N(N)) bus ();

  bus_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .i_CLK  (i_CLK),
    .i_RSTn (i_RSTn),
    .bus    (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    i_CLK = 1'b0;
    forever #5 i_CLK = ~i_CLK;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_inputs;
    bus.i_M_REQ     = '0;
    bus.i_M_WE      = '0;
    bus.i_M_HB      = '0;
    bus.i_M_CE      = '0;
    bus.i_M_ADDR    = '0;
    bus.i_M_WDATA   = '0;
    bus.i_BUS_RDATA = '0;
    bus.i_BUS_RDY   = 1'b0;
  endtask

  task automatic next_cycle;
    @(posedge i_CLK);
    #1;
  endtask

  // Leaves the bench 1 unit into a cycle whose state is IDLE with ptr = 0.
  task automatic do_reset;
    clear_inputs();
    i_RSTn = 1'b0;
    repeat (2) @(posedge i_CLK);
    @(negedge i_CLK);
    i_RSTn = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset;
    $display("[TB] test_reset");
    i_RSTn          = 1'b0;
    bus.i_M_REQ     = 2'b11;
    bus.i_M_WE      = 2'b01;
    bus.i_M_HB      = 4'b1111;
    bus.i_M_CE      = 16'hFFFF;
    bus.i_M_ADDR    = {32'h2222_2222, 32'h1111_1111};
    bus.i_M_WDATA   = {32'h4444_4444, 32'h3333_3333};
    bus.i_BUS_RDATA = 32'h5555_5555;
    bus.i_BUS_RDY   = 1'b1;
    repeat (2) @(posedge i_CLK);
    @(negedge i_CLK);
    checks++; if (bus.o_M_GNT !== 2'b00) begin errors++; $display("[TB] FAIL reset_gnt: got %b want %b", bus.o_M_GNT, 2'b00); end
    checks++; if (bus.o_M_ERR !== 2'b00) begin errors++; $display("[TB] FAIL reset_err: got %b want %b", bus.o_M_ERR, 2'b00); end
    checks++; if (bus.o_M_RDATA !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h want %h", bus.o_M_RDATA, 32'h0); end
    checks++; if (bus.o_BUS_ADDR !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h want %h", bus.o_BUS_ADDR, 32'h0); end
    checks++; if (bus.o_BUS_WDATA !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata: got %h want %h", bus.o_BUS_WDATA, 32'h0); end
    checks++; if (bus.o_BUS_WE !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b want %b", bus.o_BUS_WE, 1'b0); end
    checks++; if (bus.o_BUS_RE !== 1'b0) begin errors++; $display("[TB] FAIL reset_re: got %b want %b", bus.o_BUS_RE, 1'b0); end
    checks++; if (bus.o_BUS_HB !== 2'b00) begin errors++; $display("[TB] FAIL reset_hb: got %b want %b", bus.o_BUS_HB, 2'b00); end
    checks++; if (bus.o_BUS_CE !== 8'h00) begin errors++; $display("[TB] FAIL reset_ce: got %h want %h", bus.o_BUS_CE, 8'h00); end
    checks++; if (bus.o_OWNER !== 1'b0) begin errors++; $display("[TB] FAIL reset_owner: got %0d want %0d", bus.o_OWNER, 0); end
    clear_inputs();
  endtask

  task automatic test_single_read;
    $display("[TB] test_single_read");
    do_reset();
    bus.i_M_REQ     = 2'b01;
    bus.i_M_WE      = 2'b00;
    bus.i_M_HB      = 4'b0010;
    bus.i_M_ADDR    = {32'h0000_0200, 32'h0000_0100};
    bus.i_M_CE      = {8'h02, 8'h01};
    bus.i_BUS_RDY   = 1'b1;
    bus.i_BUS_RDATA = 32'h1234_5678;
    @(negedge i_CLK);
    checks++; if (bus.o_M_GNT !== 2'b00) begin errors++; $display("[TB] FAIL read_idle_gnt: got %b want %b", bus.o_M_GNT, 2'b00); end
    checks++; if (bus.o_BUS_RE !== 1'b0) begin errors++; $display("[TB] FAIL read_idle_re: got %b want %b", bus.o_BUS_RE, 1'b0); end
    next_cycle();
    @(negedge i_CLK);
    checks++; if (bus.o_BUS_ADDR !== 32'h0000_0100) begin errors++; $display("[TB] FAIL read_addr: got %h want %h", bus.o_BUS_ADDR, 32'h0000_0100); end
    checks++; if (bus.o_BUS_RE !== 1'b1) begin errors++; $display("[TB] FAIL read_re: got %b want %b", bus.o_BUS_RE, 1'b1); end
    checks++; if (bus.o_BUS_WE !== 1'b0) begin errors++; $display("[TB] FAIL read_we: got %b want %b", bus.o_BUS_WE, 1'b0); end
    checks++; if (bus.o_BUS_CE !== 8'h01) begin errors++; $display("[TB] FAIL read_ce: got %h want %h", bus.o_BUS_CE, 8'h01); end
    checks++; if (bus.o_BUS_HB !== 2'b10) begin errors++; $display("[TB] FAIL read_hb: got %b want %b", bus.o_BUS_HB, 2'b10); end
    checks++; if (bus.o_M_GNT !== 2'b01) begin errors++; $display("[TB] FAIL read_gnt: got %b want %b", bus.o_M_GNT, 2'b01); end
    checks++; if (bus.o_M_ERR !== 2'b00) begin errors++; $display("[TB] FAIL read_err: got %b want %b", bus.o_M_ERR, 2'b00); end
    checks++; if (bus.o_M_RDATA !== 32'h1234_5678) begin errors++; $display("[TB] FAIL read_rdata: got %h want %h", bus.o_M_RDATA, 32'h1234_5678); end
    next_cycle();
    @(negedge i_CLK);
    checks++; if (bus.o_BUS_CE !== 8'h00) begin errors++; $display("[TB] FAIL read_recover_ce: got %h want %h", bus.o_BUS_CE, 8'h00); end
    checks++; if (bus.o_BUS_RE !== 1'b0) begin errors++; $display("[TB] FAIL read_recover_re: got %b want %b", bus.o_BUS_RE, 1'b0); end
    checks++; if (bus.o_BUS_ADDR !== 32'h0) begin errors++; $display("[TB] FAIL read_recover_addr: got %h want %h", bus.o_BUS_ADDR, 32'h0); end
    checks++; if (bus.o_M_GNT !== 2'b00) begin errors++; $display("[TB] FAIL read_recover_gnt: got %b want %b", bus.o_M_GNT, 2'b00); end
    checks++; if (bus.o_M_RDATA !== 32'h0) begin errors++; $display("[TB] FAIL read_recover_rdata: got %h want %h", bus.o_M_RDATA, 32'h0); end
    next_cycle();
    bus.i_M_REQ = 2'b00;
    @(negedge i_CLK);
    checks++; if (bus.o_BUS_CE !== 8'h00) begin errors++; $display("[TB] FAIL read_no_resample_ce: got %h want %h", bus.o_BUS_CE, 8'h00); end
    checks++; if (bus.o_M_GNT !== 2'b00) begin errors++; $display("[TB] FAIL read_no_resample_gnt: got %b want %b", bus.o_M_GNT, 2'b00); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_gnt;
    logic       exp_owner;
    $display("[TB] test_round_robin");
    do_reset();
    bus.i_M_REQ     = 2'b11;
    bus.i_M_WE      = 2'b00;
    bus.i_M_ADDR    = {32'h0000_2000, 32'h0000_1000};
    bus.i_M_CE      = {8'h02, 8'h01};
    bus.i_BUS_RDY   = 1'b1;
    bus.i_BUS_RDATA = 32'h0BAD_F00D;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) next_cycle();
      @(negedge i_CLK);
      exp_gnt   = (c % 3 == 1) ? (((c / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_owner = (c == 0) ? 1'b0 : ((((c - 1) / 3) % 2) == 1);
      checks++; if (bus.o_M_GNT !== exp_gnt) begin errors++; $display("[TB] FAIL rr_gnt cycle %0d: got %b want %b", c, bus.o_M_GNT, exp_gnt); end
      checks++; if (bus.o_OWNER !== exp_owner) begin errors++; $display("[TB] FAIL rr_owner cycle %0d: got %0d want %0d", c, bus.o_OWNER, exp_owner); end
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_wait_states;
    logic [1:0] exp_gnt;
    $display("[TB] test_wait_states");
    do_reset();
    bus.i_M_REQ   = 2'b10;
    bus.i_M_WE    = 2'b10;
    bus.i_M_HB    = 4'b1001;
    bus.i_M_CE    = {8'h04, 8'h01};
    bus.i_M_ADDR  = {32'h2000_0040, 32'hAAAA_0000};
    bus.i_M_WDATA = {32'hCAFE_F00D, 32'h1111_1111};
    bus.i_BUS_RDY = 1'b0;
    @(negedge i_CLK);
    checks++; if (bus.o_M_GNT !== 2'b00) begin errors++; $display("[TB] FAIL ws_idle_gnt: got %b want %b", bus.o_M_GNT, 2'b00); end
    for (int a = 1; a <= 4; a++) begin
      next_cycle();
      if (a == 4) bus.i_BUS_RDY = 1'b1;
      @(negedge i_CLK);
      exp_gnt = (a == 4) ? 2'b10 : 2'b00;
      checks++; if (bus.o_BUS_ADDR !== 32'h2000_0040) begin errors++; $display("[TB] FAIL ws_addr cycle %0d: got %h want %h", a, bus.o_BUS_ADDR, 32'h2000_0040); end
      checks++; if (bus.o_BUS_WDATA !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL ws_wdata cycle %0d: got %h want %h", a, bus.o_BUS_WDATA, 32'hCAFE_F00D); end
      checks++; if (bus.o_BUS_WE !== 1'b1) begin errors++; $display("[TB] FAIL ws_we cycle %0d: got %b want %b", a, bus.o_BUS_WE, 1'b1); end
      checks++; if (bus.o_BUS_RE !== 1'b0) begin errors++; $display("[TB] FAIL ws_re cycle %0d: got %b want %b", a, bus.o_BUS_RE, 1'b0); end
      checks++; if (bus.o_BUS_HB !== 2'b10) begin errors++; $display("[TB] FAIL ws_hb cycle %0d: got %b want %b", a, bus.o_BUS_HB, 2'b10); end
      checks++; if (bus.o_BUS_CE !== 8'h04) begin errors++; $display("[TB] FAIL ws_ce cycle %0d: got %h want %h", a, bus.o_BUS_CE, 8'h04); end
      checks++; if (bus.o_OWNER !== 1'b1) begin errors++; $display("[TB] FAIL ws_owner cycle %0d: got %0d want %0d", a, bus.o_OWNER, 1); end
      checks++; if (bus.o_M_GNT !== exp_gnt) begin errors++; $display("[TB] FAIL ws_gnt cycle %0d: got %b want %b", a, bus.o_M_GNT, exp_gnt); end
      checks++; if (bus.o_M_ERR !== 2'b00) begin errors++; $display("[TB] FAIL ws_err cycle %0d: got %b want %b", a, bus.o_M_ERR, 2'b00); end
    end
    next_cycle();
    bus.i_M_REQ   = 2'b00;
    bus.i_BUS_RDY = 1'b0;
    @(negedge i_CLK);
    checks++; if (bus.o_BUS_WE !== 1'b0) begin errors++; $display("[TB] FAIL ws_recover_we: got %b want %b", bus.o_BUS_WE, 1'b0); end
    checks++; if (bus.o_BUS_CE !== 8'h00) begin errors++; $display("[TB] FAIL ws_recover_ce: got %h want %h", bus.o_BUS_CE, 8'h00); end
    checks++; if (bus.o_M_GNT !== 2'b00) begin errors++; $display("[TB] FAIL ws_recover_gnt: got %b want %b", bus.o_M_GNT, 2'b00); end
  endtask

  // rdy_on_last = 1 raises ready exactly on the final allowed ACCESS cycle.
  task automatic test_timeout(input bit rdy_on_last);
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_err;
    logic [31:0] exp_rdata;
    $display("[TB] test_timeout rdy_on_last=%0d", rdy_on_last);
    do_reset();
    bus.i_M_REQ     = 2'b01;
    bus.i_M_WE      = 2'b00;
    bus.i_M_ADDR    = {32'h0, 32'h0000_0300};
    bus.i_M_CE      = {8'h00, 8'h02};
    bus.i_BUS_RDATA = 32'h5555_5555;
    bus.i_BUS_RDY   = 1'b0;
    for (int a = 1; a <= TIMEOUT; a++) begin
      next_cycle();
      if (a == TIMEOUT && rdy_on_last) bus.i_BUS_RDY = 1'b1;
      @(negedge i_CLK);
      exp_gnt = (a == TIMEOUT) ? 2'b01 : 2'b00;
      exp_err = (a == TIMEOUT && !rdy_on_last) ? 2'b01 : 2'b00;
      checks++; if (bus.o_BUS_CE !== 8'h02) begin errors++; $display("[TB] FAIL to_ce cycle %0d: got %h want %h", a, bus.o_BUS_CE, 8'h02); end
      checks++; if (bus.o_M_GNT !== exp_gnt) begin errors++; $display("[TB] FAIL to_gnt cycle %0d: got %b want %b", a, bus.o_M_GNT, exp_gnt); end
      checks++; if (bus.o_M_ERR !== exp_err) begin errors++; $display("[TB] FAIL to_err cycle %0d: got %b want %b", a, bus.o_M_ERR, exp_err); end
    end
    exp_rdata = rdy_on_last ? 32'h5555_5555 : 32'hDEAD_BEEF;
    checks++; if (bus.o_M_RDATA !== exp_rdata) begin errors++; $display("[TB] FAIL to_rdata: got %h want %h", bus.o_M_RDATA, exp_rdata); end
    next_cycle();
    bus.i_M_REQ   = 2'b00;
    bus.i_BUS_RDY = 1'b0;
    @(negedge i_CLK);
    checks++; if (bus.o_BUS_CE !== 8'h00) begin errors++; $display("[TB] FAIL to_recover_ce: got %h want %h", bus.o_BUS_CE, 8'h00); end
    checks++; if (bus.o_M_GNT !== 2'b00) begin errors++; $display("[TB] FAIL to_recover_gnt: got %b want %b", bus.o_M_GNT, 2'b00); end
    checks++; if (bus.o_M_ERR !== 2'b00) begin errors++; $display("[TB] FAIL to_recover_err: got %b want %b", bus.o_M_ERR, 2'b00); end
  endtask

  task automatic test_abort;
    $display("[TB] test_abort");
    do_reset();
    // M0 completes first so ptr moves on to M1.
    bus.i_M_REQ   = 2'b01;
    bus.i_M_ADDR  = {32'h0000_4000, 32'h0000_5000};
    bus.i_M_CE    = {8'h10, 8'h20};
    bus.i_BUS_RDY = 1'b1;
    next_cycle();
    @(negedge i_CLK);
    checks++; if (bus.o_M_GNT !== 2'b01) begin errors++; $display("[TB] FAIL abort_pre_gnt: got %b want %b", bus.o_M_GNT, 2'b01); end
    next_cycle();
    bus.i_M_REQ   = 2'b00;
    bus.i_BUS_RDY = 1'b0;
    next_cycle();
    bus.i_M_REQ = 2'b10;
    next_cycle();
    @(negedge i_CLK);
    checks++; if (bus.o_BUS_CE !== 8'h10) begin errors++; $display("[TB] FAIL abort_access_ce: got %h want %h", bus.o_BUS_CE, 8'h10); end
    checks++; if (bus.o_OWNER !== 1'b1) begin errors++; $display("[TB] FAIL abort_access_owner: got %0d want %0d", bus.o_OWNER, 1); end
    checks++; if (bus.o_M_GNT !== 2'b00) begin errors++; $display("[TB] FAIL abort_access_gnt: got %b want %b", bus.o_M_GNT, 2'b00); end
    next_cycle();
    bus.i_M_REQ   = 2'b00;
    bus.i_BUS_RDY = 1'b1;
    @(negedge i_CLK);
    checks++; if (bus.o_M_GNT !== 2'b00) begin errors++; $display("[TB] FAIL abort_drop_gnt: got %b want %b", bus.o_M_GNT, 2'b00); end
    checks++; if (bus.o_M_ERR !== 2'b00) begin errors++; $display("[TB] FAIL abort_drop_err: got %b want %b", bus.o_M_ERR, 2'b00); end
    next_cycle();
    bus.i_M_REQ = 2'b11;
    @(negedge i_CLK);
    checks++; if (bus.o_BUS_CE !== 8'h00) begin errors++; $display("[TB] FAIL abort_idle_ce: got %h want %h", bus.o_BUS_CE, 8'h00); end
    checks++; if (bus.o_BUS_RE !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle_re: got %b want %b", bus.o_BUS_RE, 1'b0); end
    checks++; if (bus.o_M_GNT !== 2'b00) begin errors++; $display("[TB] FAIL abort_idle_gnt: got %b want %b", bus.o_M_GNT, 2'b00); end
    // ptr must still favour M1 when both request.
    next_cycle();
    @(negedge i_CLK);
    checks++; if (bus.o_OWNER !== 1'b1) begin errors++; $display("[TB] FAIL abort_ptr_owner: got %0d want %0d", bus.o_OWNER, 1); end
    checks++; if (bus.o_BUS_ADDR !== 32'h0000_4000) begin errors++; $display("[TB] FAIL abort_ptr_addr: got %h want %h", bus.o_BUS_ADDR, 32'h0000_4000); end
    checks++; if (bus.o_M_GNT !== 2'b10) begin errors++; $display("[TB] FAIL abort_ptr_gnt: got %b want %b", bus.o_M_GNT, 2'b10); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid_access;
    $display("[TB] test_reset_mid_access");
    do_reset();
    // First transfer moves ptr to 1.
    bus.i_M_REQ   = 2'b01;
    bus.i_BUS_RDY = 1'b1;
    next_cycle();
    next_cycle();
    bus.i_M_REQ   = 2'b00;
    bus.i_BUS_RDY = 1'b0;
    next_cycle();
    bus.i_M_REQ  = 2'b01;
    bus.i_M_WE   = 2'b01;
    bus.i_M_CE   = {8'h40, 8'h08};
    bus.i_M_ADDR = {32'h0000_6000, 32'h0000_7000};
    next_cycle();
    @(negedge i_CLK);
    checks++; if (bus.o_BUS_CE !== 8'h08) begin errors++; $display("[TB] FAIL rst_mid_pre_ce: got %h want %h", bus.o_BUS_CE, 8'h08); end
    checks++; if (bus.o_BUS_WE !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_pre_we: got %b want %b", bus.o_BUS_WE, 1'b1); end
    #2;
    bus.i_BUS_RDY = 1'b1;
    i_RSTn        = 1'b0;
    #1;
    checks++; if (bus.o_BUS_CE !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_ce: got %h want %h", bus.o_BUS_CE, 8'h00); end
    checks++; if (bus.o_BUS_WE !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_we: got %b want %b", bus.o_BUS_WE, 1'b0); end
    checks++; if (bus.o_BUS_RE !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_re: got %b want %b", bus.o_BUS_RE, 1'b0); end
    checks++; if (bus.o_BUS_ADDR !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_addr: got %h want %h", bus.o_BUS_ADDR, 32'h0); end
    checks++; if (bus.o_M_GNT !== 2'b00) begin errors++; $display("[TB] FAIL rst_mid_gnt: got %b want %b", bus.o_M_GNT, 2'b00); end
    // After release ptr is 0 again, so M0 wins a simultaneous request.
    @(negedge i_CLK);
    bus.i_M_REQ = 2'b11;
    bus.i_M_WE  = 2'b00;
    i_RSTn      = 1'b1;
    @(posedge i_CLK);
    @(negedge i_CLK);
    checks++; if (bus.o_OWNER !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_ptr_owner: got %0d want %0d", bus.o_OWNER, 0); end
    checks++; if (bus.o_M_GNT !== 2'b01) begin errors++; $display("[TB] FAIL rst_mid_ptr_gnt: got %b want %b", bus.o_M_GNT, 2'b01); end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    i_RSTn = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_states();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_abort();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter and multiplexer that shares the single peripheral bus between N bus masters: the core load/store path plus additional masters such as a DMA engine or debug port. It sits between the masters' request/grant interfaces and the bus slaves. It serialises transfers, steers the granted master's address, data and control onto the bus, and sequences each transfer through a grant/wait-state/timeout state machine. Masters stall on REQ & ~GNT, the same handshake the core already uses.

## Interface
Parameters:
- N, 2, number of masters (2..4); master 0 is the core.
- TIMEOUT, 16, maximum cycles a transfer waits for i_BUS_RDY before being terminated with an error (≥2).

Ports:
- i_CLK  in  1  single clock, rising edge.
- i_RSTn  in  1  asynchronous, active-low reset.
- i_M_REQ  in  N  per-master transfer request, held until granted.
- i_M_WE  in  N  per-master write enable (0 = read).
- i_M_HB  in  2N  per-master size code; master k uses bits [2k+1:2k].
- i_M_CE  in  8N  per-master one-hot slave select.
- i_M_ADDR  in  32N  per-master address.
- i_M_WDATA  in  32N  per-master write data.
- o_M_GNT  out  N  one-cycle completion/grant pulse to the owner.
- o_M_ERR  out  N  one-cycle timeout error pulse, coincident with o_M_GNT.
- o_M_RDATA  out  32  read data, broadcast to all masters, valid while o_M_GNT is high.
- o_BUS_ADDR  out  32  bus address.
- o_BUS_WDATA  out  32  bus write data.
- o_BUS_WE  out  1  bus write enable.
- o_BUS_RE  out  1  bus read enable.
- o_BUS_HB  out  2  bus size code.
- o_BUS_CE  out  8  bus slave select.
- i_BUS_RDATA  in  32  slave read data.
- i_BUS_RDY  in  1  slave completes the transfer this cycle.
- o_OWNER  out  clog2(N)  index of the current or last owner (debug).

## Operation
- States: IDLE, ACCESS, RECOVER.
- IDLE:
  - If any i_M_REQ bit is set, pick the first requester at or after priority pointer `ptr`, rotating modulo N.
  - Latch it as the owner and move to ACCESS.
  - With no requests, stay in IDLE.
- ACCESS:
  - The bus outputs carry the owner's ADDR, WDATA, WE, HB and CE, selected combinationally from the latched owner index.
  - o_BUS_RE = ~WE.
  - Wait-state counter `wcnt` starts at 0 and increments each ACCESS cycle.
- ACCESS completes when i_BUS_RDY = 1:
  - o_M_GNT[owner] = 1 and o_M_RDATA = i_BUS_RDATA.
  - `ptr` = (owner+1) mod N; next state is RECOVER.
- ACCESS times out when wcnt = TIMEOUT−1 and i_BUS_RDY = 0:
  - o_M_GNT[owner] = 1, o_M_ERR[owner] = 1, o_M_RDATA = 32'hDEAD_BEEF.
  - `ptr` advances; next state is RECOVER.
- Abort: if i_M_REQ[owner] drops during ACCESS, go to IDLE with no GNT or ERR. `ptr` is unchanged and the bus is de-asserted.
- RECOVER: the bus is idle for one cycle and the state returns to IDLE. This ensures the completed master's still-asserted REQ for the same transfer is never re-sampled.
- Outside ACCESS:
  - o_BUS_WE, o_BUS_RE and o_BUS_CE are 0; o_BUS_ADDR, o_BUS_WDATA and o_BUS_HB are 0.
  - o_M_GNT, o_M_ERR and o_M_RDATA are 0.
- An i_BUS_RDY that arrives on the timeout cycle wins: normal completion, no ERR.
- New requests that arrive during ACCESS or RECOVER wait; they are arbitrated at the next IDLE.

## Timing
- Reset (async, i_RSTn = 0): state IDLE, ptr 0, owner 0, wcnt 0. All outputs are 0 immediately, including o_OWNER.
- Minimum latency: REQ first seen at edge t (state IDLE). ACCESS runs in cycle t+1, and GNT is high in t+1 if RDY = 1. RECOVER is cycle t+2, IDLE is t+3.
- Peak throughput is one transfer per 3 cycles per bus; back-to-back transfers from one master are spaced 3 cycles apart.
- o_M_GNT, o_M_ERR and o_M_RDATA are combinational on i_BUS_RDY and state.
- A timeout asserts GNT and ERR in the TIMEOUT-th ACCESS cycle.
- Fairness: with all masters continuously requesting, each master is granted exactly once per N transfers.
- Reset mid-ACCESS: the bus de-asserts asynchronously, no GNT is issued, and ptr returns to 0.

## Test plan
- Single read: N=2; M0 REQ, WE=0, ADDR=0x100, CE=0x01; slave RDY=1 with RDATA=0x1234_5678. Required: bus ADDR=0x100 and RE=1 in cycle t+1; GNT[0] and M_RDATA=0x1234_5678 in t+1; bus idle in t+2.
- Round-robin: M0 and M1 both request continuously with RDY always 1. Required: grant order 0,1,0,1, GNT pulses 3 cycles apart, o_OWNER alternating.
- Wait states: M1 write, WDATA=0xCAFE_F00D, RDY low for 3 ACCESS cycles then high. Required: bus outputs stable for 4 cycles, a single GNT[1] on the 4th, no ERR.
- Timeout: TIMEOUT=16, RDY held at 0. Required: GNT[0] and ERR[0] in the 16th ACCESS cycle, M_RDATA=0xDEAD_BEEF, then RECOVER. With RDY=1 on the 16th cycle instead: GNT without ERR.
- Abort and reset: M1 drops REQ in its 2nd ACCESS cycle. Required: IDLE next cycle, no GNT, ptr still points at M1. Separately, assert i_RSTn low mid-ACCESS. Required: CE, WE and RE drop to 0 without waiting for a clock edge.
